vec_response_checker: RTL and testbench
=======================================

# vec_response_checker

Synthesizable response checker for the lab's combinational circuit benches: the receiving end of the test-vector stream. A stimulus source drives a DUT one vector per step; this block samples the DUT outputs on a strobe, compares them against a loadable table of expected results, counts mismatches, and reports pass/fail. It lets the team move result checking from waveform inspection into hardware, or into any bench as a drop-in scoreboard.

## Interface
- `NUM_VECS`, 6: number of vectors per run; must be ≥ 1.
- `OUT_W`, 2: width of the DUT response, for example `{sum, cout}`.
- `IDX_W`, `$clog2(NUM_VECS)` (min 1): index width.
- `CNT_W`, `$clog2(NUM_VECS+1)`: error counter width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `exp_wr_en`  in  1  write strobe for the expected-value table.
- `exp_wr_addr`  in  IDX_W  table entry to write.
- `exp_wr_data`  in  OUT_W  expected response.
- `start`  in  1  single-cycle pulse that begins a run.
- `sample_valid`  in  1  DUT output is stable; compare this cycle.
- `dut_out`  in  OUT_W  DUT response.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while `done` is high; 1 iff `err_count == 0`.
- `vec_idx`  out  IDX_W  index of the next vector to be compared.
- `err_count`  out  CNT_W  number of mismatches this run; saturates at NUM_VECS.
- `first_err_valid`  out  1  a mismatch has occurred this run.
- `first_err_idx`  out  IDX_W  index of the first mismatch.
- `first_err_got`  out  OUT_W  `dut_out` captured at the first mismatch.

## Operation
- Storage: table `exp_mem[0:NUM_VECS-1]` of OUT_W bits.
  - Written on `exp_wr_en` in IDLE or DONE only; writes in RUN are ignored.
  - Writes with `exp_wr_addr ≥ NUM_VECS` are ignored.
  - Reset does not clear the table.
- FSM states:
  - IDLE → RUN on `start`. Entering RUN clears `vec_idx`, `err_count`, `first_err_*` and `pass`.
  - RUN: on each `sample_valid`, compare `dut_out` with `exp_mem[vec_idx]`.
    - On mismatch: increment `err_count`. If `first_err_valid` is 0, latch `first_err_idx = vec_idx` and `first_err_got = dut_out`, and set `first_err_valid`.
    - Increment `vec_idx`.
    - On the sample where `vec_idx == NUM_VECS-1`, go to DONE and hold `vec_idx` at NUM_VECS-1.
  - DONE: outputs hold. `pass = (err_count == 0)`. `start` → RUN (rerun).
- In RUN, `start` is ignored. In IDLE and DONE, `sample_valid` is ignored.
- If `start` and `exp_wr_en` occur in the same cycle in IDLE or DONE, the write takes effect, and the run begins on the next cycle with the updated table.

## Timing
- Reset values (on async `rst_n` low): state IDLE, `busy = 0`, `done = 0`, `pass = 0`, `vec_idx = 0`, `err_count = 0`, `first_err_valid = 0`, `first_err_idx = 0`, `first_err_got = 0`.
- `start` sampled at edge N → `busy = 1` after edge N.
- Compare latency: `sample_valid` at edge N → `err_count`, `vec_idx` and `first_err_*` update after edge N (one cycle).
- Final sample at edge N → `done = 1` and `busy = 0` after edge N. `pass` is valid in the same cycle as `done`.
- Back-to-back `sample_valid` on every cycle is supported; there is no required gap.
- Reset asserted mid-run: return immediately to the reset values and abandon the partial run. The table contents are kept.
- `err_count` saturates at NUM_VECS; it never wraps.

## Configuration
- `CHECKER_HALT_ON_ERR_EN`:
  - Defined: the first mismatch in RUN moves the FSM directly to DONE on that edge. `err_count = 1`, `pass = 0`, and `vec_idx` holds the failing index.
  - Undefined (default): the run always completes all NUM_VECS compares, and every mismatch is counted.

## Test plan
- Reset, then all-match run: load exp = {0,1,1,2,1,2}, pulse `start`, drive the matching `dut_out` with `sample_valid` on 6 consecutive cycles → `done = 1` after the 6th edge, `pass = 1`, `err_count = 0`, `first_err_valid = 0`.
- Single mismatch: same table, `dut_out = 3` at vector 2 → `err_count = 1`, `first_err_idx = 2`, `first_err_got = 3`, `pass = 0`. With `CHECKER_HALT_ON_ERR_EN` defined: `done` asserts after the vector-2 edge and `vec_idx = 2`.
- Multiple mismatches and saturation: `NUM_VECS = 6`, all `dut_out` wrong → `err_count = 6`, `first_err_idx = 0`.
- Gapped strobes and ignored events: `sample_valid` every 3rd cycle → the same result as back-to-back. A `start` pulse and an `exp_wr_en` write during RUN → no restart and no table change.
- Async reset mid-run: assert `rst_n = 0` after 3 samples, between clock edges → outputs go to reset values immediately. A new run then completes with the unchanged table and `pass = 1`.
- Rerun from DONE: change `exp_mem[5]` while in DONE, pulse `start` → counters clear and the new expected value is used.

Source files
------------

// File: rtl/vec_response_checker.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vec_response_checker : strobe-sampled response checker against a loadable |
// | expected table. Option macro: CHECKER_HALT_ON_ERR_EN.   Rev 1.0           |
// +---------------------------------------------------------------------------+
module vec_response_checker #(
  parameter int NUM_VECS = 6,
  parameter int OUT_W    = 2,
  parameter int IDX_W    = (NUM_VECS > 1) ? $clog2(NUM_VECS) : 1,
  parameter int CNT_W    = $clog2(NUM_VECS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exp_wr_en_i,
  input  logic [IDX_W-1:0] exp_wr_addr_i,
  input  logic [OUT_W-1:0] exp_wr_data_i,
  input  logic             start_i,
  input  logic             sample_valid_i,
  input  logic [OUT_W-1:0] dut_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [IDX_W-1:0] vec_idx_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic             first_err_valid_o,
  output logic [IDX_W-1:0] first_err_idx_o,
  output logic [OUT_W-1:0] first_err_got_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(NUM_VECS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic [IDX_W-1:0] fei_q, fei_d;
  logic [OUT_W-1:0] feg_q, feg_d;
  logic             pass_q, pass_d;

  logic [OUT_W-1:0] exp_mem_q [NUM_VECS];
  logic             wr_ok;
  logic             mismatch;

  // The table survives reset so a bench can reload it once and rerun freely.
  assign wr_ok = exp_wr_en_i && (state_q != RUN) && (32'(exp_wr_addr_i) < NUM_VECS);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      exp_mem_q[exp_wr_addr_i] <= exp_wr_data_i;
    end
  end

  assign mismatch = (dut_out_i != exp_mem_q[vec_idx_q]);

  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    err_d     = err_q;
    fev_d     = fev_q;
    fei_d     = fei_q;
    feg_d     = feg_q;
    pass_d    = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = RUN;
          vec_idx_d = '0;
          err_d     = '0;
          fev_d     = 1'b0;
          fei_d     = '0;
          feg_d     = '0;
          pass_d    = 1'b0;
        end
      end
      RUN: begin
        if (sample_valid_i) begin
          if (mismatch) begin
            err_d = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = vec_idx_q;
              feg_d = dut_out_i;
            end
          end
`ifdef CHECKER_HALT_ON_ERR_EN
          // Halting leaves vec_idx pointing at the failing vector.
          if (mismatch) begin
            state_d = DONE;
            pass_d  = 1'b0;
          end else if (vec_idx_q == LAST_IDX) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end else begin
            vec_idx_d = vec_idx_q + 1'b1;
          end
`else
          if (vec_idx_q == LAST_IDX) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end else begin
            vec_idx_d = vec_idx_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_idx_q <= '0;
      err_q     <= '0;
      fev_q     <= 1'b0;
      fei_q     <= '0;
      feg_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      err_q     <= err_d;
      fev_q     <= fev_d;
      fei_q     <= fei_d;
      feg_q     <= feg_d;
      pass_q    <= pass_d;
    end
  end

  assign busy_o            = (state_q == RUN);
  assign done_o            = (state_q == DONE);
  assign pass_o            = pass_q;
  assign vec_idx_o         = vec_idx_q;
  assign err_count_o       = err_q;
  assign first_err_valid_o = fev_q;
  assign first_err_idx_o   = fei_q;
  assign first_err_got_o   = feg_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_response_checker.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_vec_response_checker : directed bench with a queue-based result model. |
// | Honours CHECKER_HALT_ON_ERR_EN.                          Rev 1.0          |
// +---------------------------------------------------------------------------+
module tb_vec_response_checker;
  localparam int NV = 6;
  localparam int OW = 2;
  localparam int IW = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [OW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          sv = 1'b0;
  logic [OW-1:0] dut_out = '0;
  logic          busy, done, pass, fev;
  logic [IW-1:0] vidx, feidx;
  logic [CW-1:0] errc;
  logic [OW-1:0] fegot;

  int n_tests = 0;
  int n_fail  = 0;

  vec_response_checker #(.NUM_VECS(NV), .OUT_W(OW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .exp_wr_en_i      (wr_en),
    .exp_wr_addr_i    (wr_addr),
    .exp_wr_data_i    (wr_data),
    .start_i          (start),
    .sample_valid_i   (sv),
    .dut_out_i        (dut_out),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .vec_idx_o        (vidx),
    .err_count_o      (errc),
    .first_err_valid_o(fev),
    .first_err_idx_o  (feidx),
    .first_err_got_o  (fegot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run is just the list of responses sampled so far, each paired
  // with the table entry it was judged against; every output derives from it.
  bit            m_run  = 1'b0;
  bit            m_done = 1'b0;
  logic [OW-1:0] m_tab [NV];
  logic [OW-1:0] m_got [$];
  logic [OW-1:0] m_exp [$];

  always @(negedge rst_n) begin
    m_run = 1'b0; m_done = 1'b0; m_got.delete(); m_exp.delete();
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_run) begin
        if (sv) begin
          int idx;
          idx = m_got.size();
          m_exp.push_back(m_tab[idx]);
          m_got.push_back(dut_out);
          if (m_got.size() == NV) begin m_run = 1'b0; m_done = 1'b1; end
`ifdef CHECKER_HALT_ON_ERR_EN
          if (dut_out != m_tab[idx]) begin m_run = 1'b0; m_done = 1'b1; end
`endif
        end
      end else begin
        if (wr_en && int'(wr_addr) < NV) m_tab[wr_addr] = wr_data;
        if (start) begin
          m_run = 1'b1; m_done = 1'b0; m_got.delete(); m_exp.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    int errs, first, n;
    errs = 0; first = -1; n = m_got.size();
    foreach (m_got[i]) if (m_got[i] != m_exp[i]) begin
      errs++;
      if (first < 0) first = i;
    end
    check("busy", int'(busy), int'(m_run));
    check("done", int'(done), int'(m_done));
    check("pass", int'(pass), int'(m_done && errs == 0));
    check("vec_idx", int'(vidx), m_done ? n - 1 : n);
    check("err_count", int'(errc), errs);
    check("first_err_valid", int'(fev), int'(first >= 0));
    check("first_err_idx", int'(feidx), (first >= 0) ? first : 0);
    check("first_err_got", int'(fegot), (first >= 0) ? int'(m_got[first]) : 0);
  end

  logic [OW-1:0] tab0  [NV] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2};
  logic [OW-1:0] r_bad [NV] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd2};
  logic [OW-1:0] r_all [NV] = '{2'd1, 2'd0, 2'd0, 2'd3, 2'd0, 2'd3};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_run(input logic [OW-1:0] resp [NV], input int gap, input bit inject);
    start = 1'b1; tick(); start = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < NV; i++) begin
      for (int g = 0; g < gap; g++) begin
        if (inject && i == 2 && g == 0) begin
          start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 2'd3;
        end
        tick(); start = 1'b0; wr_en = 1'b0;
      end
      sv = 1'b1; dut_out = resp[i]; tick(); sv = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    check("reset busy", int'(busy), 0);
    check("reset err_count", int'(errc), 0);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      wr_en = 1'b1; wr_addr = IW'(i); wr_data = tab0[i]; tick();
    end
    wr_addr = 3'd7; wr_data = 2'd3; tick(); wr_en = 1'b0;

    do_run(tab0, 0, 1'b0);
    check("allmatch done", int'(done), 1);
    check("allmatch pass", int'(pass), 1);
    check("allmatch err_count", int'(errc), 0);
    check("allmatch first_err_valid", int'(fev), 0);

    do_run(r_bad, 0, 1'b0);
    check("single err_count", int'(errc), 1);
    check("single first_err_idx", int'(feidx), 2);
    check("single first_err_got", int'(fegot), 3);
    check("single pass", int'(pass), 0);
`ifdef CHECKER_HALT_ON_ERR_EN
    check("halt vec_idx", int'(vidx), 2);
`else
    do_run(r_all, 0, 1'b0);
    check("allwrong err_count", int'(errc), 6);
    check("allwrong first_err_idx", int'(feidx), 0);
`endif

    do_run(tab0, 2, 1'b1);
    check("gapped pass", int'(pass), 1);
    check("gapped err_count", int'(errc), 0);

    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv = 1'b1; dut_out = tab0[i]; tick(); sv = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    check("async rst busy", int'(busy), 0);
    check("async rst vec_idx", int'(vidx), 0);
    #2 rst_n = 1'b1;
    tick();
    do_run(tab0, 0, 1'b0);
    check("post-reset pass", int'(pass), 1);

    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 2'd0;
    do_run(tab0, 0, 1'b0);
    check("rerun err_count", int'(errc), 1);
    check("rerun first_err_idx", int'(feidx), 5);
    check("rerun first_err_got", int'(fegot), 2);
    check("rerun vec_idx", int'(vidx), 5);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
